// File: rtl/fx_frame_sequencer_if.sv
// Memory-side bundle for fx_frame_sequencer: read request/grant/return
// and the write-back strobe. master = sequencer, slave = memory/arbiter.
interface fx_frame_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output rd_req, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_gnt, rd_valid, rd_data
  );

  modport slave (
    input  rd_req, rd_addr, wr_en, wr_addr, wr_data,
    output rd_gnt, rd_valid, rd_data
  );
endinterface

// File: rtl/fx_frame_sequencer.sv
// Streams one frame of samples: memory read -> effect -> write-back.
// Ports: clk, rst (sync, high); start/base_addr/frame_len/fx_en_cfg/abort
// command; busy/done status; mem (read + write-back bundle);
// fx_en/fx_addr_in/fx_audio_in to effect, fx_addr_out/fx_audio_out back.
module fx_frame_sequencer #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 16,
  parameter int LEN_W     = 12,
  parameter int ADDR_STEP = 1,
  parameter int FX_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              fx_en_cfg,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  fx_frame_sequencer_if.master mem,
  output logic              fx_en,
  output logic [ADDR_W-1:0] fx_addr_in,
  output logic [DATA_W-1:0] fx_audio_in,
  input  logic [ADDR_W-1:0] fx_addr_out,
  input  logic [DATA_W-1:0] fx_audio_out
);
  localparam int CW = LEN_W + 1;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_DRAIN, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [LEN_W-1:0]  len_q;
  logic              en_q;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] ret_ptr;
  logic [CW-1:0]     iss_cnt;
  logic [CW-1:0]     ret_cnt;
  logic [CW-1:0]     wr_cnt;
  logic [CW-1:0]     len_x;
  logic [FX_LAT:0]   vpipe;

  logic act;
  logic accept;
  logic take;
  logic kill;
  logic last_gnt;
  logic rd_req;
  logic wr_en;

  assign len_x    = {1'b0, len_q};
  assign act      = (state == S_ISSUE) || (state == S_DRAIN);
  assign accept   = (state == S_IDLE) && start;
  assign kill     = act && abort;
  // Returns beyond the frame length are dropped, as are any in IDLE/DONE.
  assign take     = act && !abort && mem.rd_valid && (ret_cnt < len_x);
  assign last_gnt = mem.rd_gnt && ((iss_cnt + CW'(1)) == len_x);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    rd_req   = 1'b0;
    fx_en    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start)
          state_nx = (frame_len == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        busy   = 1'b1;
        rd_req = 1'b1;
        fx_en  = en_q;
        if (abort)         state_nx = S_IDLE;
        else if (last_gnt) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        busy  = 1'b1;
        fx_en = en_q;
        if (abort)                state_nx = S_IDLE;
        else if (wr_cnt == len_x) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Valid bit enters vpipe[0] together with fx_audio_in; the effect
  // output is then valid FX_LAT cycles later at vpipe[FX_LAT].
  assign wr_en = vpipe[FX_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q       <= '0;
      en_q        <= 1'b0;
      rd_ptr      <= '0;
      ret_ptr     <= '0;
      iss_cnt     <= '0;
      ret_cnt     <= '0;
      wr_cnt      <= '0;
      vpipe       <= '0;
      fx_addr_in  <= '0;
      fx_audio_in <= '0;
    end else if (kill) begin
      rd_ptr      <= '0;
      ret_ptr     <= '0;
      iss_cnt     <= '0;
      ret_cnt     <= '0;
      wr_cnt      <= '0;
      vpipe       <= '0;
      fx_addr_in  <= '0;
      fx_audio_in <= '0;
    end else begin
      vpipe <= {vpipe[FX_LAT-1:0], take};
      if (accept) begin
        len_q   <= frame_len;
        en_q    <= fx_en_cfg;
        rd_ptr  <= base_addr;
        ret_ptr <= base_addr;
        iss_cnt <= '0;
        ret_cnt <= '0;
        wr_cnt  <= '0;
      end
      if (state == S_ISSUE && mem.rd_gnt) begin
        rd_ptr  <= rd_ptr + STEP;
        iss_cnt <= iss_cnt + CW'(1);
      end
      if (take) begin
        fx_audio_in <= mem.rd_data;
        fx_addr_in  <= ret_ptr;
        ret_ptr     <= ret_ptr + STEP;
        ret_cnt     <= ret_cnt + CW'(1);
      end
      if (wr_en) wr_cnt <= wr_cnt + CW'(1);
    end
  end

  assign mem.rd_req  = rd_req;
  assign mem.rd_addr = rd_req ? rd_ptr : '0;
  assign mem.wr_en   = wr_en;
  assign mem.wr_addr = wr_en ? fx_addr_out : '0;
  assign mem.wr_data = wr_en ? fx_audio_out : '0;
endmodule

// File: tb/tb_fx_frame_sequencer.sv
// Bench for fx_frame_sequencer: FX_LAT=1 and FX_LAT=3 instances share
// commands; memory and effect models plus scoreboard live here.
module tb_fx_frame_sequencer;
  localparam int AW = 32;
  localparam int DW = 16;
  localparam int LW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, abort, fx_en_cfg;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] frame_len;
  logic          alt, inj;
  logic          tgl = 1'b0;
  int            cyc = 0;

  fx_frame_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) m0 ();
  fx_frame_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) m3 ();

  logic          busy0, done0, fxen0, busy3, done3, fxen3;
  logic [AW-1:0] fai0, fao0, fai3, fao3;
  logic [DW-1:0] fdi0, fdo0, fdi3, fdo3;

  fx_frame_sequencer #(.FX_LAT(1)) u0 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .frame_len(frame_len), .fx_en_cfg(fx_en_cfg), .abort(abort),
    .busy(busy0), .done(done0), .mem(m0), .fx_en(fxen0),
    .fx_addr_in(fai0), .fx_audio_in(fdi0),
    .fx_addr_out(fao0), .fx_audio_out(fdo0)
  );

  fx_frame_sequencer #(.FX_LAT(3)) u3 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .frame_len(frame_len), .fx_en_cfg(fx_en_cfg), .abort(abort),
    .busy(busy3), .done(done3), .mem(m3), .fx_en(fxen3),
    .fx_addr_in(fai3), .fx_audio_in(fdi3),
    .fx_addr_out(fao3), .fx_audio_out(fdo3)
  );

  function automatic logic [DW-1:0] smp(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction

  function automatic logic [DW-1:0] fx(input logic [DW-1:0] d,
                                       input logic e);
    logic signed [DW-1:0] s;
    s = d;
    return e ? DW'(s >>> 1) : d;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    tgl <= ~tgl;
  end

  assign m0.rd_gnt = alt ? tgl : 1'b1;
  assign m3.rd_gnt = alt ? tgl : 1'b1;

  // Memory: one-cycle read latency, data derived from the address.
  logic          rv0 = 1'b0, rv3 = 1'b0;
  logic [DW-1:0] rd0 = '0, rd3 = '0;
  always @(posedge clk) begin
    rv0 <= m0.rd_req && m0.rd_gnt;
    rd0 <= smp(m0.rd_addr);
    rv3 <= m3.rd_req && m3.rd_gnt;
    rd3 <= smp(m3.rd_addr);
  end
  assign m0.rd_valid = rv0 | inj;
  assign m0.rd_data  = inj ? 16'h7777 : rd0;
  assign m3.rd_valid = rv3 | inj;
  assign m3.rd_data  = inj ? 16'h7777 : rd3;

  // Effect stand-ins: halve the sample when enabled, latency 1 and 3.
  logic [AW-1:0] e0a = '0;
  logic [DW-1:0] e0d = '0;
  logic [AW-1:0] e3a [3];
  logic [DW-1:0] e3d [3];
  always @(posedge clk) begin
    e0a    <= fai0;
    e0d    <= fx(fdi0, fxen0);
    e3a[0] <= fai3;
    e3d[0] <= fx(fdi3, fxen3);
    e3a[1] <= e3a[0];
    e3d[1] <= e3d[0];
    e3a[2] <= e3a[1];
    e3d[2] <= e3d[1];
  end
  assign fao0 = e0a;
  assign fdo0 = e0d;
  assign fao3 = e3a[2];
  assign fdo3 = e3d[2];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Scoreboard state
  logic [AW-1:0] exp_rd0, exp_wr0, exp_wr3, prev_addr0;
  logic          cur_en, prev_req0, prev_gnt0;
  int g0, w0, w3, d0, d3, rq0, bz0, hold_bad, fxen_bad;
  int frv0, fwr0, frv3, fwr3, fd0, cs;

  task automatic mon_clear();
    g0 = 0; w0 = 0; w3 = 0; d0 = 0; d3 = 0; rq0 = 0; bz0 = 0;
    hold_bad = 0; fxen_bad = 0;
    frv0 = -1; fwr0 = -1; frv3 = -1; fwr3 = -1; fd0 = -1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (m0.rd_req) rq0++;
      if (busy0) bz0++;
      if (m0.rd_req && m0.rd_gnt) begin
        chk("rd_addr", 64'(m0.rd_addr), 64'(exp_rd0));
        exp_rd0 = exp_rd0 + 1;
        g0++;
      end
      if (prev_req0 && !prev_gnt0 && m0.rd_req &&
          m0.rd_addr !== prev_addr0)
        hold_bad++;
      prev_req0  = m0.rd_req;
      prev_gnt0  = m0.rd_gnt;
      prev_addr0 = m0.rd_addr;
      if (m0.rd_valid && frv0 < 0) frv0 = cyc;
      if (m3.rd_valid && frv3 < 0) frv3 = cyc;
      if (m0.wr_en) begin
        if (fwr0 < 0) fwr0 = cyc;
        chk("wr_addr0", 64'(m0.wr_addr), 64'(exp_wr0));
        chk("wr_data0", 64'(m0.wr_data), 64'(fx(smp(exp_wr0), cur_en)));
        exp_wr0 = exp_wr0 + 1;
        w0++;
      end
      if (m3.wr_en) begin
        if (fwr3 < 0) fwr3 = cyc;
        chk("wr_addr3", 64'(m3.wr_addr), 64'(exp_wr3));
        chk("wr_data3", 64'(m3.wr_data), 64'(fx(smp(exp_wr3), cur_en)));
        exp_wr3 = exp_wr3 + 1;
        w3++;
      end
      if (fxen0 && !busy0) fxen_bad++;
      if (fxen3 && !busy3) fxen_bad++;
      if (done0) begin
        d0++;
        if (fd0 < 0) fd0 = cyc;
      end
      if (done3) d3++;
    end
  end

  task automatic launch(input logic [AW-1:0] b, input logic [LW-1:0] l,
                        input logic e, input logic a);
    @(negedge clk); #1;
    mon_clear();
    exp_rd0 = b; exp_wr0 = b; exp_wr3 = b; cur_en = e;
    base_addr = b; frame_len = l; fx_en_cfg = e; alt = a;
    start = 1'b1;
    cs = cyc;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (d0 > 0 && d3 > 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
    #1;
    chk($sformatf("%s done_seen", nm), 64'(ok), 64'd1);
  endtask

  task automatic finish_checks(input string nm, input int n);
    chk($sformatf("%s grants", nm), 64'(g0), 64'(n));
    chk($sformatf("%s writes0", nm), 64'(w0), 64'(n));
    chk($sformatf("%s writes3", nm), 64'(w3), 64'(n));
    chk($sformatf("%s done0_cycles", nm), 64'(d0), 64'd1);
    chk($sformatf("%s done3_cycles", nm), 64'(d3), 64'd1);
    chk($sformatf("%s rd_addr_hold", nm), 64'(hold_bad), 64'd0);
    chk($sformatf("%s fx_en_idle", nm), 64'(fxen_bad), 64'd0);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [LW-1:0] len;
    logic          en;
    logic          alt;
    int            exp_n;
    int            exp_lag0;
    int            exp_lag3;
  } vec_t;

  vec_t vt [6];

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; fx_en_cfg = 1'b0;
    base_addr = '0; frame_len = '0; alt = 1'b0; inj = 1'b0;
    exp_rd0 = '0; exp_wr0 = '0; exp_wr3 = '0; prev_addr0 = '0;
    cur_en = 1'b0; prev_req0 = 1'b0; prev_gnt0 = 1'b0; cs = 0;
    mon_clear();

    vt[0] = '{32'h0000_0100, 12'd4, 1'b1, 1'b0, 4, 2, 4};
    vt[1] = '{32'h0000_0100, 12'd4, 1'b1, 1'b1, 4, 2, 4};
    vt[2] = '{32'h0000_0040, 12'd0, 1'b1, 1'b0, 0, 0, 0};
    vt[3] = '{32'hFFFF_FFFE, 12'd4, 1'b0, 1'b0, 4, 2, 4};
    vt[4] = '{32'h0000_2000, 12'd1, 1'b0, 1'b1, 1, 2, 4};
    vt[5] = '{32'h0000_55AA, 12'd7, 1'b1, 1'b0, 7, 2, 4};

    repeat (3) @(negedge clk);
    #1;
    chk("rst busy", 64'(busy0), 64'd0);
    chk("rst done", 64'(done0), 64'd0);
    chk("rst rd_req", 64'(m0.rd_req), 64'd0);
    chk("rst wr_en", 64'(m0.wr_en), 64'd0);
    chk("rst fx_en", 64'(fxen0), 64'd0);
    chk("rst rd_addr", 64'(m0.rd_addr), 64'd0);
    chk("rst fx_addr_in", 64'(fai0), 64'd0);
    chk("rst fx_audio_in", 64'(fdi0), 64'd0);
    rst = 1'b0;

    foreach (vt[i]) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      launch(vt[i].base, vt[i].len, vt[i].en, vt[i].alt);
      if (vt[i].exp_n > 0) begin
        chk({nm, " busy"}, 64'(busy0), 64'd1);
        chk({nm, " fx_en"}, 64'(fxen0), 64'(vt[i].en));
        chk({nm, " rd_req"}, 64'(m0.rd_req), 64'd1);
      end else begin
        chk({nm, " busy"}, 64'(busy0), 64'd0);
      end
      wait_end(nm);
      finish_checks(nm, vt[i].exp_n);
      if (vt[i].exp_n > 0) begin
        chk({nm, " lag1"}, 64'(fwr0 - frv0), 64'(vt[i].exp_lag0));
        chk({nm, " lag3"}, 64'(fwr3 - frv3), 64'(vt[i].exp_lag3));
      end else begin
        // Accept at the first edge, DONE on the next: one or two edges.
        chk({nm, " done_lat"},
            64'((fd0 - cs >= 1) && (fd0 - cs <= 2)), 64'd1);
        chk({nm, " no_rd_req"}, 64'(rq0), 64'd0);
      end
    end

    // Abort after two grants of an 8-sample frame.
    begin
      bit ok;
      ok = 1'b0;
      launch(32'h0000_0200, 12'd8, 1'b1, 1'b0);
      for (int i = 0; i < 50; i++) begin
        if (g0 >= 2) begin
          ok = 1'b1;
          break;
        end
        @(negedge clk); #1;
      end
      chk("abort reach_2_grants", 64'(ok), 64'd1);
      abort = 1'b1;
      @(negedge clk); #1;
      abort = 1'b0;
      chk("abort busy", 64'(busy0), 64'd0);
      chk("abort rd_req", 64'(m0.rd_req), 64'd0);
      chk("abort wr_en", 64'(m0.wr_en), 64'd0);
      chk("abort fx_en", 64'(fxen0), 64'd0);
      chk("abort busy3", 64'(busy3), 64'd0);
      chk("abort wr_en3", 64'(m3.wr_en), 64'd0);
      mon_clear();
      inj = 1'b1;
      @(negedge clk); #1;
      inj = 1'b0;
      repeat (8) @(negedge clk);
      #1;
      chk("abort late_writes0", 64'(w0), 64'd0);
      chk("abort late_writes3", 64'(w3), 64'd0);
      chk("abort rd_req_after", 64'(rq0), 64'd0);
      chk("abort no_done0", 64'(d0), 64'd0);
      chk("abort no_done3", 64'(d3), 64'd0);
      launch(32'h0000_0300, 12'd3, 1'b1, 1'b0);
      wait_end("post_abort");
      finish_checks("post_abort", 3);
    end

    // Start pulsed during ISSUE, then during DONE.
    begin
      bit ok;
      ok = 1'b0;
      launch(32'h0000_0400, 12'd6, 1'b0, 1'b1);
      base_addr = 32'h0000_0999; frame_len = 12'd2; fx_en_cfg = 1'b1;
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk); #1;
        if (done0) begin
          ok = 1'b1;
          break;
        end
      end
      chk("restart done_seen", 64'(ok), 64'd1);
      base_addr = 32'h0000_0800; frame_len = 12'd3;
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      finish_checks("restart", 6);
      rq0 = 0; bz0 = 0;
      repeat (5) @(negedge clk);
      #1;
      chk("start_in_done busy", 64'(bz0), 64'd0);
      chk("start_in_done rd_req", 64'(rq0), 64'd0);
    end

    // Reset in the middle of a frame.
    launch(32'h0000_0500, 12'd5, 1'b1, 1'b0);
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    chk("midrst busy", 64'(busy0), 64'd0);
    chk("midrst rd_req", 64'(m0.rd_req), 64'd0);
    chk("midrst fx_en", 64'(fxen0), 64'd0);
    chk("midrst fx_addr_in", 64'(fai0), 64'd0);
    chk("midrst wr_en", 64'(m0.wr_en), 64'd0);
    rst = 1'b0;
    mon_clear();
    repeat (6) @(negedge clk);
    #1;
    chk("midrst no_writes", 64'(w0 + w3), 64'd0);
    chk("midrst no_done", 64'(d0 + d3), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
